// File: rtl/id_dqz_control_unit_if.sv
// Upstream FIFO read port and downstream IDCT FIFO write port of the dequantizer.
// master is the dequantizer side, slave is the FIFO/environment side.
interface id_dqz_control_unit_if;
    logic         ff_empty;
    logic [103:0] x;
    logic         ff_rdreq;
    logic         ds_full;
    logic         wrreq;
    logic [127:0] y;
    logic         out_last;

    modport master (
        input  ff_empty,
        input  x,
        input  ds_full,
        output ff_rdreq,
        output wrreq,
        output y,
        output out_last
    );

    modport slave (
        output ff_empty,
        output x,
        output ds_full,
        input  ff_rdreq,
        input  wrreq,
        input  y,
        input  out_last
    );
endinterface

// File: rtl/id_dqz_control_unit.sv
// JPEG dequantizer + inverse zigzag: zigzag rows in, dequantized natural-order rows out,
// through a 2x64 ping-pong buffer so block fill and block drain overlap.
module id_dqz_control_unit (
    input  logic                         clk,
    input  logic                         reset_n,
    id_dqz_control_unit_if.master        bus
);

    // Natural (raster) position of each zigzag index.
    localparam logic [5:0] ZzToNat [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [7:0] QLuma [64] = '{
        8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] QChroma [64] = '{
        8'd17,  8'd18,  8'd24,  8'd47,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd18,  8'd21,  8'd26,  8'd66,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd24,  8'd26,  8'd56,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd47,  8'd66,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99
    };

    // Issue side
    logic [3:0]        r_iss_cnt;
    logic              r_wbank;
    // Store side
    logic              r_st_vld;
    logic [2:0]        r_st_cnt;
    logic              r_sbank;
    logic [1:0]        r_blk_cnt;
    // Shared bank state
    logic [1:0]        r_full;
    logic [1:0]        r_tab_sel;
    // Read side
    logic              r_rbank;
    logic [2:0]        r_rd_row;
    logic              r_wrreq;
    logic              r_out_last;
    logic [127:0]      r_y;

    logic signed [12:0] r_mem [2][64];

    logic              w_rdreq;
    logic              w_rd_go;
    logic [5:0]        w_idx  [8];
    logic [7:0]        w_q    [8];
    logic signed [20:0] w_prod [8];
    logic [15:0]       w_sat  [8];
    logic [127:0]      w_y_row;

    // Gated by reset so the strobe drops the moment reset asserts.
    assign w_rdreq = reset_n & ~bus.ff_empty & ~r_full[r_wbank] & (r_iss_cnt < 4'd8);
    assign w_rd_go = r_full[r_rbank] & ~bus.ds_full;

    assign bus.ff_rdreq = w_rdreq;
    assign bus.wrreq    = r_wrreq;
    assign bus.out_last = r_out_last;
    assign bus.y        = r_y;

    always_comb begin
        w_y_row = '0;
        for (int i = 0; i < 8; i++) begin
            w_idx[i]  = {r_rd_row, 3'(i)};
            w_q[i]    = r_tab_sel[r_rbank] ? QChroma[w_idx[i]] : QLuma[w_idx[i]];
            w_prod[i] = 21'(r_mem[r_rbank][w_idx[i]]) * 21'($signed({1'b0, w_q[i]}));
            if (w_prod[i] > 21'sd32767) begin
                w_sat[i] = 16'h7fff;
            end else if (w_prod[i] < -21'sd32768) begin
                w_sat[i] = 16'h8000;
            end else begin
                w_sat[i] = w_prod[i][15:0];
            end
            w_y_row[16*i +: 16] = w_sat[i];
        end
    end

    // Buffer contents need no reset: a bank is only read once its full flag is set.
    always_ff @(posedge clk) begin
        if (r_st_vld) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[r_sbank][ZzToNat[{r_st_cnt, 3'(i)}]] <= $signed(bus.x[13*i +: 13]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iss_cnt  <= '0;
            r_wbank    <= 1'b0;
            r_st_vld   <= 1'b0;
            r_st_cnt   <= '0;
            r_sbank    <= 1'b0;
            r_blk_cnt  <= '0;
            r_full     <= '0;
            r_tab_sel  <= '0;
            r_rbank    <= 1'b0;
            r_rd_row   <= '0;
            r_wrreq    <= 1'b0;
            r_out_last <= 1'b0;
            r_y        <= '0;
        end else begin
            if (w_rdreq) begin
                if (r_iss_cnt == 4'd7) begin
                    r_iss_cnt <= '0;
                    r_wbank   <= ~r_wbank;
                end else begin
                    r_iss_cnt <= r_iss_cnt + 4'd1;
                end
            end

            r_wrreq    <= w_rd_go;
            r_out_last <= w_rd_go & (r_rd_row == 3'd7);
            if (w_rd_go) begin
                r_y      <= w_y_row;
                r_rd_row <= r_rd_row + 3'd1;
                if (r_rd_row == 3'd7) begin
                    r_full[r_rbank] <= 1'b0;
                    r_rbank         <= ~r_rbank;
                end
            end

            // Store after the release so a set always wins; they never hit the same bank.
            r_st_vld <= w_rdreq;
            if (r_st_vld) begin
                r_st_cnt <= r_st_cnt + 3'd1;
                if (r_st_cnt == 3'd7) begin
                    r_full[r_sbank]    <= 1'b1;
                    r_tab_sel[r_sbank] <= r_blk_cnt[1];
                    r_blk_cnt          <= r_blk_cnt + 2'd1;
                    r_sbank            <= ~r_sbank;
                end
            end
        end
    end

endmodule
